// File: rtl/hsv_core_alu_fifo.sv
// Two-stage RV32/RV64 integer ALU with a credit-controlled output FIFO.
// Optional MIN/MAX/MINU/MAXU ops (codes 10-13) are enabled by defining HSV_ALU_MINMAX_EN.
module hsv_core_alu_fifo #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_core,
    input  logic             rst_core_n,
    input  logic             flush_req,
    output logic             flush_ack,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int EW  = XLEN + TAG_W + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
`ifdef HSV_ALU_MINMAX_EN
    localparam logic [3:0] OP_MIN  = 4'd10;
    localparam logic [3:0] OP_MAX  = 4'd11;
    localparam logic [3:0] OP_MINU = 4'd12;
    localparam logic [3:0] OP_MAXU = 4'd13;
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [XLEN-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             flush_ack_q, flush_ack_d;
    logic [EW-1:0]    fifo_mem_q [FIFO_DEPTH];

    logic [CW:0]      credit;
    logic             accept, wr_en, pop;
    logic [SHW-1:0]   shamt;
    logic             lt_s, lt_u, alu_ill;
    logic [XLEN-1:0]  alu_res;
    logic [EW-1:0]    rd_entry;

    // Credits count the stage 1 slot too, so in_ready never waits on out_ready.
    assign credit    = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
    assign in_ready  = ~flush_req & (credit < DEPTH_W);
    assign accept    = in_valid & in_ready;
    assign out_valid = (count_q != '0) & ~flush_req;
    assign pop       = out_valid & out_ready;
    assign wr_en     = s1_valid_q & ~flush_req;
    assign flush_ack = flush_ack_q;

    assign shamt = s1_b_q[SHW-1:0];
    assign lt_s  = $signed(s1_a_q) < $signed(s1_b_q);
    assign lt_u  = s1_a_q < s1_b_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (s1_op_q)
            OP_ADD:  alu_res = s1_a_q + s1_b_q;
            OP_SUB:  alu_res = s1_a_q - s1_b_q;
            OP_SLL:  alu_res = s1_a_q << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_SRL:  alu_res = s1_a_q >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(s1_a_q) >>> shamt);
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_AND:  alu_res = s1_a_q & s1_b_q;
`ifdef HSV_ALU_MINMAX_EN
            OP_MIN:  alu_res = lt_s ? s1_a_q : s1_b_q;
            OP_MAX:  alu_res = lt_s ? s1_b_q : s1_a_q;
            OP_MINU: alu_res = lt_u ? s1_a_q : s1_b_q;
            OP_MAXU: alu_res = lt_u ? s1_b_q : s1_a_q;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d  = accept;
        s1_op_d     = accept ? in_op  : s1_op_q;
        s1_a_d      = accept ? in_a   : s1_a_q;
        s1_b_d      = accept ? in_b   : s1_b_q;
        s1_tag_d    = accept ? in_tag : s1_tag_q;
        flush_ack_d = flush_req;
        wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush_req) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            flush_ack_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            flush_ack_q <= flush_ack_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk_core) begin
        if (wr_en) fifo_mem_q[wr_ptr_q] <= {alu_ill, s1_tag_q, alu_res};
    end

    assign rd_entry = fifo_mem_q[rd_ptr_q];
    assign {out_illegal, out_tag, out_result} = out_valid ? rd_entry : '0;

endmodule

// File: tb/tb_hsv_core_alu_fifo.sv
// Directed, table-driven bench for hsv_core_alu_fifo (XLEN=32, TAG_W=5, FIFO_DEPTH=4).
module tb_hsv_core_alu_fifo;
    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_ack;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    hsv_core_alu_fifo #(.XLEN(32), .TAG_W(5), .FIFO_DEPTH(4)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drives ADD requests (a=n, b=100, tag=n) with out_ready low until `want` accepts.
    task automatic fill(input int want, output int got);
        got = 0;
        for (int c = 0; c < 10 && got < want; c++) begin
            logic acc;
            @(negedge clk_core);
            in_valid = 1'b1; in_op = 4'd0; in_a = 32'(got); in_b = 32'd100;
            in_tag = 5'(got);
            acc = in_ready;
            @(posedge clk_core);
            if (acc) got++;
        end
        @(negedge clk_core);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h1,        5'd3,  32'h00000000, 1'b0};
        vecs[1]  = '{4'd1,  32'h5,        32'h7,        5'd1,  32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{4'd7,  32'h80000000, 32'h24,       5'd2,  32'hF8000000, 1'b0};
        vecs[3]  = '{4'd7,  32'h40000000, 32'h4,        5'd4,  32'h04000000, 1'b0};
        vecs[4]  = '{4'd2,  32'h1,        32'd31,       5'd5,  32'h80000000, 1'b0};
        vecs[5]  = '{4'd6,  32'h80000000, 32'h0,        5'd6,  32'h80000000, 1'b0};
        vecs[6]  = '{4'd6,  32'h80000000, 32'h21,       5'd7,  32'h40000000, 1'b0};
        vecs[7]  = '{4'd3,  32'hFFFFFFFF, 32'h1,        5'd8,  32'h00000001, 1'b0};
        vecs[8]  = '{4'd4,  32'hFFFFFFFF, 32'h1,        5'd9,  32'h00000000, 1'b0};
        vecs[9]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 32'h0FF00FF0, 1'b0};
        vecs[10] = '{4'd8,  32'h0F0F0000, 32'h000000F0, 5'd11, 32'h0F0F00F0, 1'b0};
        vecs[11] = '{4'd9,  32'h12345678, 32'h0000FFFF, 5'd12, 32'h00005678, 1'b0};
        vecs[12] = '{4'd14, 32'h1,        32'h2,        5'd13, 32'h00000000, 1'b1};
        vecs[13] = '{4'd15, 32'hDEADBEEF, 32'h2,        5'd14, 32'h00000000, 1'b1};
`ifdef HSV_ALU_MINMAX_EN
        vecs[14] = '{4'd10, 32'hFFFFFFFF, 32'h2,        5'd15, 32'hFFFFFFFF, 1'b0};
        vecs[15] = '{4'd12, 32'hFFFFFFFF, 32'h2,        5'd16, 32'h00000002, 1'b0};
`else
        vecs[14] = '{4'd10, 32'hFFFFFFFF, 32'h2,        5'd15, 32'h00000000, 1'b1};
        vecs[15] = '{4'd12, 32'hFFFFFFFF, 32'h2,        5'd16, 32'h00000000, 1'b1};
`endif

        repeat (2) @(negedge clk_core);
        chk("rst_in_ready", in_ready, 1'b0 | 1'b1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flush_ack", flush_ack, 0);
        chk("rst_out_result", out_result, 0);
        rst_core_n = 1'b1;
        @(negedge clk_core);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Table: one op at a time, out_ready high, fixed two-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
            in_tag = vecs[i].tag;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(posedge clk_core);
            @(negedge clk_core);
            in_valid = 1'b0;
            chk($sformatf("v%0d_not_early", i), out_valid, 0);
            @(negedge clk_core);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_tag", i), out_tag, vecs[i].tag);
            chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
        end
        @(negedge clk_core);
        chk("drain_empty", out_valid, 0);
        chk("drain_zero_result", out_result, 0);

        // Full FIFO: exactly four accepts with out_ready low.
        out_ready = 1'b0;
        fill(8, n);
        chk("full_accepts", n, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_tag", out_tag, 0);
        @(negedge clk_core);
        chk("full_head_stable", out_result, 100);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d_valid", i), out_valid, 1);
            chk($sformatf("pop%0d_tag", i), out_tag, i);
            chk($sformatf("pop%0d_result", i), out_result, i + 100);
            @(negedge clk_core);
            if (i == 0) chk("in_ready_after_pop", in_ready, 1);
        end
        chk("pop_empty", out_valid, 0);

        // Flush with three queued and one in stage 1.
        out_ready = 1'b0;
        fill(4, n);
        chk("flush_fill", n, 4);
        flush_req = 1'b1;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_ack_lag", flush_ack, 0);
        @(negedge clk_core);
        flush_req = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_ack_rise", flush_ack, 1);
        chk("flush_cleared", out_valid, 0);
        chk("flush_in_ready_back", in_ready, 1);
        @(negedge clk_core);
        chk("flush_ack_fall", flush_ack, 0);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) n++;
            @(negedge clk_core);
        end
        chk("flush_no_stale", n, 0);

        // Pipeline still works after the flush.
        in_valid = 1'b1; in_op = 4'd0; in_a = 32'd7; in_b = 32'd8; in_tag = 5'd21;
        @(negedge clk_core);
        in_valid = 1'b0;
        @(negedge clk_core);
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_result", out_result, 15);
        chk("post_flush_tag", out_tag, 21);
        @(negedge clk_core);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
